multicycle_control_fsm: RTL and testbench



---
 rtl/multicycle_control_fsm.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// rtl/multicycle_control_fsm.sv - multi-cycle control FSM with memory handshake and retire counter
// Moore controls are registered against the next state; FETCH/MEMWRITE/BRANCH strobes mix in mem_ready/zero.
module multicycle_control_fsm #(
  parameter int ILEN         = 32,
  parameter int CNT_W        = 32,
  parameter bit TRAP_ILLEGAL = 1'b1,
  parameter bit XORID_EN     = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [ILEN-1:0]  instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ResultSrc,
  output logic             data_select,
  output logic             illegal,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_UPPER    = 4'd12,
    S_TRAP     = 4'd15
  } state_t;

  typedef struct packed {
    logic       mem_req;
    logic       adr_src;
    logic       reg_write;
    logic       pc_update;
    logic       branch;
    logic       data_select;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] result_src;
  } ctrl_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_XORID = 7'b0001011;

  localparam state_t S_ILLEGAL = TRAP_ILLEGAL ? S_TRAP : S_FETCH;

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic             r_illegal;
  logic [CNT_W-1:0] r_retired;

  logic [6:0] w_op;
  state_t     w_next;
  logic       w_retire;
  logic       w_fetch_go;
  logic       w_unused_instr;

  function automatic state_t f_next(input state_t s, input logic [6:0] op, input logic rdy);
    state_t n;
    n = S_FETCH;
    case (s)
      S_FETCH:    n = rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op)
          OP_L, OP_S:        n = S_MEMADR;
          OP_R:              n = S_EXECR;
          OP_I:              n = S_EXECI;
          OP_XORID:          n = XORID_EN ? S_EXECI : S_ILLEGAL;
          OP_B:              n = S_BRANCH;
          OP_JAL:            n = S_JAL;
          OP_JALR:           n = S_JALR;
          OP_LUI, OP_AUIPC:  n = S_UPPER;
          default:           n = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   n = (op == OP_S) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  n = rdy ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: n = rdy ? S_FETCH : S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: n = S_ALUWB;
      S_TRAP:     n = S_TRAP;
      default:    n = S_FETCH;
    endcase
    return n;
  endfunction

  // Controls for state s, given the state it is entered from and the decoded opcode.
  function automatic ctrl_t f_ctrl(input state_t s, input state_t from, input logic [6:0] op);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:    c.mem_req = 1'b1;
      S_DECODE:   begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; end
      S_MEMADR:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      S_MEMREAD, S_MEMWRITE: begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1'b1; end
      S_EXECR:    begin c.alu_src_a = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    begin c.reg_write = 1'b1; c.data_select = (from == S_JAL); end
      S_BRANCH:   begin c.alu_src_a = 2'b10; c.alu_op = 2'b01; c.branch = 1'b1; end
      S_JAL: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;  c.data_select = 1'b1;
      end
      S_JALR: begin
        c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.result_src = 2'b10;
        c.pc_update = 1'b1;  c.reg_write = 1'b1;  c.data_select = 1'b1;
      end
      S_UPPER: begin
        c.alu_src_b   = 2'b01; c.alu_op = 2'b11; c.result_src = 2'b10; c.reg_write = 1'b1;
        c.alu_src_a   = (op == OP_AUIPC) ? 2'b01 : 2'b10;
        c.data_select = (op == OP_AUIPC);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_op           = instr[6:0];
  assign w_unused_instr = ^instr[ILEN-1:7];
  assign w_next         = f_next(r_state, w_op, mem_ready);
  assign w_retire       = (r_state != S_FETCH) && (r_state != S_TRAP) && (w_next == S_FETCH);
  assign w_fetch_go     = (r_state == S_FETCH) && mem_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_ctrl    <= f_ctrl(S_FETCH, S_FETCH, 7'd0);
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= f_ctrl(w_next, r_state, w_op);
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire)         r_retired <= r_retired + CNT_W'(1);
    end
  end

  // Every output reads as zero while reset is held low.
  assign mem_req     = rst_n & r_ctrl.mem_req;
  assign AdrSrc      = rst_n & r_ctrl.adr_src;
  assign IRWrite     = rst_n & w_fetch_go;
  assign PCWrite     = rst_n & (w_fetch_go | r_ctrl.pc_update | (r_ctrl.branch & zero));
  assign MemWrite    = rst_n & (r_state == S_MEMWRITE) & mem_ready;
  assign RegWrite    = rst_n & r_ctrl.reg_write;
  assign ALUSrcA     = {2{rst_n}} & r_ctrl.alu_src_a;
  assign ALUSrcB     = {2{rst_n}} & (w_fetch_go ? 2'b10 : r_ctrl.alu_src_b);
  assign ALUOp       = {2{rst_n}} & r_ctrl.alu_op;
  assign ResultSrc   = {2{rst_n}} & (w_fetch_go ? 2'b10 : r_ctrl.result_src);
  assign data_select = rst_n & r_ctrl.data_select;
  assign illegal     = rst_n & r_illegal;
  assign retired     = {CNT_W{rst_n}} & r_retired;
  assign state_o     = {4{rst_n}} & r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// tb/tb_multicycle_control_fsm.sv - scoreboard bench for multicycle_control_fsm
// Per-cycle expectations come from instruction-level state sequences; two extra instances cover parameter variants.
module tb_multicycle_control_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, zero, mem_ready;
  logic [31:0] instr;
  logic        mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, data_select, illegal;
  logic [1:0]  ALUSrcA, ALUSrcB, ALUOp, ResultSrc;
  logic [31:0] retired;
  logic [3:0]  state_o;

  multicycle_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ResultSrc(ResultSrc), .data_select(data_select), .illegal(illegal),
    .retired(retired), .state_o(state_o)
  );

  logic        rst1_n, rdy1, zero1;
  logic [31:0] instr1;
  logic        d1_req, d1_adr, d1_irw, d1_pcw, d1_mw, d1_rw, d1_ds, d1_ill;
  logic [1:0]  d1_a, d1_b, d1_op, d1_rs, d1_ret;
  logic [3:0]  d1_st;
  logic        d2_req, d2_adr, d2_irw, d2_pcw, d2_mw, d2_rw, d2_ds, d2_ill;
  logic [1:0]  d2_a, d2_b, d2_op, d2_rs, d2_ret;
  logic [3:0]  d2_st;

  multicycle_control_fsm #(.CNT_W(2), .TRAP_ILLEGAL(1'b1), .XORID_EN(1'b0)) dut_trap (
    .clk(clk), .rst_n(rst1_n), .instr(instr1), .zero(zero1), .mem_ready(rdy1),
    .mem_req(d1_req), .AdrSrc(d1_adr), .IRWrite(d1_irw), .PCWrite(d1_pcw),
    .MemWrite(d1_mw), .RegWrite(d1_rw), .ALUSrcA(d1_a), .ALUSrcB(d1_b),
    .ALUOp(d1_op), .ResultSrc(d1_rs), .data_select(d1_ds), .illegal(d1_ill),
    .retired(d1_ret), .state_o(d1_st)
  );

  multicycle_control_fsm #(.CNT_W(2), .TRAP_ILLEGAL(1'b0), .XORID_EN(1'b0)) dut_nop (
    .clk(clk), .rst_n(rst1_n), .instr(instr1), .zero(zero1), .mem_ready(rdy1),
    .mem_req(d2_req), .AdrSrc(d2_adr), .IRWrite(d2_irw), .PCWrite(d2_pcw),
    .MemWrite(d2_mw), .RegWrite(d2_rw), .ALUSrcA(d2_a), .ALUSrcB(d2_b),
    .ALUOp(d2_op), .ResultSrc(d2_rs), .data_select(d2_ds), .illegal(d2_ill),
    .retired(d2_ret), .state_o(d2_st)
  );

  typedef struct packed {
    logic [3:0]  st;
    logic        req, adr, irw, pcw, mw, rw;
    logic [1:0]  a, b, op, rs;
    logic        ds, ill;
    logic [31:0] ret;
  } exp_t;

  localparam logic [6:0] O_R = 7'h33, O_I = 7'h13, O_L = 7'h03, O_S = 7'h23, O_B = 7'h63;
  localparam logic [6:0] O_JAL = 7'h6F, O_JALR = 7'h67, O_LUI = 7'h37, O_AUIPC = 7'h17, O_X = 7'h0B;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          ret_m = 0;
  logic [31:0] cur_instr = 32'd0;

  // Expected control word for one cycle spent in a named step of an instruction.
  function automatic exp_t e_of(input logic [3:0] st, input logic rdy, input logic z,
                                input logic ds_hold, input logic auipc);
    exp_t e;
    e = '0;
    e.st  = st;
    e.ret = 32'(ret_m);
    case (st)
      4'd0:  begin e.req = 1; if (rdy) begin e.irw = 1; e.pcw = 1; e.b = 2; e.rs = 2; end end
      4'd1:  begin e.a = 1; e.b = 1; end
      4'd2:  begin e.a = 2; e.b = 1; end
      4'd3:  begin e.req = 1; e.adr = 1; end
      4'd4:  begin e.rs = 1; e.rw = 1; end
      4'd5:  begin e.req = 1; e.adr = 1; e.mw = rdy; end
      4'd6:  begin e.a = 2; e.op = 2; end
      4'd7:  begin e.a = 2; e.b = 1; e.op = 2; end
      4'd8:  begin e.rw = 1; e.ds = ds_hold; end
      4'd9:  begin e.a = 2; e.op = 1; e.pcw = z; end
      4'd10: begin e.a = 1; e.b = 2; e.pcw = 1; e.ds = 1; end
      4'd11: begin e.a = 2; e.b = 1; e.rs = 2; e.pcw = 1; e.rw = 1; e.ds = 1; end
      4'd12: begin e.b = 1; e.op = 3; e.rs = 2; e.rw = 1; e.a = auipc ? 2'd1 : 2'd2; e.ds = auipc; end
      4'd15: e.ill = 1;
      default: e = e;
    endcase
    return e;
  endfunction

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [10] = '{O_R, O_I, O_L, O_S, O_B, O_JAL, O_JALR, O_LUI, O_AUIPC, O_X};
    logic [31:0] v;
    v = $urandom();
    return {v[31:7], ops[$urandom_range(0, 9)]};
  endfunction

  task automatic cyc(input logic rst, input logic rdy, input logic z, input exp_t e);
    @(posedge clk);
    #1;
    rst_n = rst; instr = cur_instr; mem_ready = rdy; zero = z;
    q.push_back(e);
  endtask

  // One instruction: fw FETCH waits, mw memory waits, zf = forced zero in BRANCH (-1 = random).
  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw, input int zf, input bit mid_rst);
    logic [6:0] op;
    logic       r, z;
    cur_instr = ins;
    op = ins[6:0];
    for (int i = 0; i < fw; i++) cyc(1, 0, rb(), e_of(0, 0, 0, 0, 0));
    cyc(1, 1, rb(), e_of(0, 1, 0, 0, 0));
    r = rb();
    cyc(1, r, rb(), e_of(1, r, 0, 0, 0));
    case (op)
      O_R: begin cyc(1, rb(), rb(), e_of(6, 0, 0, 0, 0)); cyc(1, rb(), rb(), e_of(8, 0, 0, 0, 0)); end
      O_I, O_X: begin cyc(1, rb(), rb(), e_of(7, 0, 0, 0, 0)); cyc(1, rb(), rb(), e_of(8, 0, 0, 0, 0)); end
      O_L: begin
        cyc(1, rb(), rb(), e_of(2, 0, 0, 0, 0));
        for (int i = 0; i < mw; i++) begin
          if (mid_rst && i == 1) begin
            cyc(0, 0, rb(), '0);
            ret_m = 0;
            return;
          end
          cyc(1, 0, rb(), e_of(3, 0, 0, 0, 0));
        end
        cyc(1, 1, rb(), e_of(3, 1, 0, 0, 0));
        cyc(1, rb(), rb(), e_of(4, 0, 0, 0, 0));
      end
      O_S: begin
        cyc(1, rb(), rb(), e_of(2, 0, 0, 0, 0));
        for (int i = 0; i < mw; i++) cyc(1, 0, rb(), e_of(5, 0, 0, 0, 0));
        cyc(1, 1, rb(), e_of(5, 1, 0, 0, 0));
      end
      O_B: begin
        z = (zf < 0) ? rb() : logic'(zf);
        cyc(1, rb(), z, e_of(9, 0, z, 0, 0));
      end
      O_JAL: begin cyc(1, rb(), rb(), e_of(10, 0, 0, 0, 0)); cyc(1, rb(), rb(), e_of(8, 0, 0, 1, 0)); end
      O_JALR: cyc(1, rb(), rb(), e_of(11, 0, 0, 0, 0));
      O_LUI, O_AUIPC: cyc(1, rb(), rb(), e_of(12, 0, 0, 0, op == O_AUIPC));
      default: begin
        for (int i = 0; i < 3; i++) cyc(1, rb(), rb(), e_of(15, 0, 0, 0, 0));
        return;
      end
    endcase
    ret_m++;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e, a;
    if (q.size() > 0) begin
      e = q.pop_front();
      a = '{st: state_o, req: mem_req, adr: AdrSrc, irw: IRWrite, pcw: PCWrite, mw: MemWrite,
            rw: RegWrite, a: ALUSrcA, b: ALUSrcB, op: ALUOp, rs: ResultSrc, ds: data_select,
            ill: illegal, ret: retired};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle t=%0t got=%h want=%h", $time, a, e);
      end
      if (PCWrite && MemWrite) begin
        bad++;
        $display("FAIL pcw_mw_overlap t=%0t got=1 want=0", $time);
      end
    end
  end

  initial begin
    rst_n = 0; mem_ready = 0; zero = 0; instr = 0;
    rst1_n = 0; rdy1 = 1; zero1 = 0; instr1 = 32'h00000013;

    cyc(0, 0, 0, '0);
    ret_m = 0;
    do_instr(32'h002081B3, 0, 0, -1, 0);
    do_instr(32'h0000A103, 0, 3, -1, 0);
    do_instr(32'h00208463, 0, 0, 1, 0);
    do_instr(32'h00208463, 0, 0, 0, 0);
    do_instr({25'h1234567, O_X}, 1, 0, -1, 0);
    for (int n = 0; n < 150; n++)
      do_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), -1, 0);
    do_instr(32'h0000A103, 1, 3, -1, 1);
    do_instr(32'h002081B3, 0, 0, -1, 0);
    do_instr(32'h0000007F, 1, 0, -1, 0);
    cyc(0, 1, 0, '0);
    ret_m = 0;
    cyc(1, 0, 0, e_of(0, 0, 0, 0, 0));
    do_instr({25'h0ABCDEF, O_JAL}, 0, 0, -1, 0);
    repeat (2) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    @(negedge clk);
    rst1_n = 1;
    for (int k = 1; k <= 5; k++) begin
      repeat (4) @(posedge clk);
      @(negedge clk);
      chk("nop_retired_w2_trap", 32'(d1_ret), 32'(k % 4));
      chk("nop_retired_w2_nop", 32'(d2_ret), 32'(k % 4));
    end
    instr1 = {25'd0, O_X};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("xorid_dis_state_trap", 32'(d1_st), 32'd15);
    chk("xorid_dis_illegal", 32'(d1_ill), 32'd1);
    chk("xorid_dis_state_nop", 32'(d2_st), 32'd0);
    chk("xorid_dis_retired_nop", 32'(d2_ret), 32'd2);
    instr1 = 32'h0000007F;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("illegal_nop_retired", 32'(d2_ret), 32'd3);
    chk("illegal_nop_flag", 32'(d2_ill), 32'd0);
    chk("trap_held_state", 32'(d1_st), 32'd15);
    chk("trap_held_illegal", 32'(d1_ill), 32'd1);
    chk("trap_held_retired", 32'(d1_ret), 32'd1);
    rst1_n = 0;
    @(posedge clk);
    #1;
    rst1_n = 1;
    @(negedge clk);
    chk("trap_reset_state", 32'(d1_st), 32'd0);
    chk("trap_reset_illegal", 32'(d1_ill), 32'd0);
    chk("trap_reset_retired", 32'(d1_ret), 32'd0);
    chk("trap_reset_mem_req", 32'(d1_req), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
